// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg: shared widths, field positions, control-word layout and
// sequencer state encoding for the micro_sequencer block.
// Optional feature macro: MICRO_SEQ_STEP_EN (single-step input).
package micro_seq_pkg;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned CS_DEPTH = 1 << ADDR_W;
  localparam int unsigned MIR_W    = 28;
  localparam int unsigned HOLD_W   = 2;
  localparam int unsigned JAM_W    = 3;
  localparam int unsigned CW_W     = 41;
  localparam int unsigned OPC_W    = 8;

  localparam logic [ADDR_W-1:0] HALT_ADDR = 8'hFF;

  // mir field positions
  localparam int unsigned MIR_SHIFT_LSB = 26;
  localparam int unsigned MIR_ALU_LSB   = 20;
  localparam int unsigned MIR_WRITE_BIT = 19;
  localparam int unsigned MIR_READ_BIT  = 18;
  localparam int unsigned MIR_ADDR_LSB  = 14;
  localparam int unsigned MIR_C_LSB     = 4;
  localparam int unsigned MIR_B_LSB     = 0;

  // control-word slice positions
  localparam int unsigned CW_MIR_LSB  = 0;
  localparam int unsigned CW_HOLD_LSB = 28;
  localparam int unsigned CW_JAM_LSB  = 30;
  localparam int unsigned CW_NEXT_LSB = 33;

  // JAM bit indices
  localparam int unsigned JAM_Z  = 0;
  localparam int unsigned JAM_N  = 1;
  localparam int unsigned JAM_PC = 2;

  // Control store word: {next_addr, jam, hold, mir}
  typedef struct packed {
    logic [ADDR_W-1:0] next_addr;
    logic [JAM_W-1:0]  jam;
    logic [HOLD_W-1:0] hold;
    logic [MIR_W-1:0]  mir;
  } cw_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HALT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: control/status bundle between the sequencer and its
// environment. MICRO_SEQ_STEP_EN adds the step input.
interface micro_sequencer_if;
  import micro_seq_pkg::*;

  logic              start;
  logic              alu_n;
  logic              alu_z;
  logic [OPC_W-1:0]  mbr_opcode;
  logic              cs_we;
  logic [ADDR_W-1:0] cs_waddr;
  logic [CW_W-1:0]   cs_wdata;
  logic [MIR_W-1:0]  mir;
  logic [ADDR_W-1:0] mpc;
  logic              running;
  logic              halted;
`ifdef MICRO_SEQ_STEP_EN
  logic              step;

  modport master (
    output start, alu_n, alu_z, mbr_opcode, cs_we, cs_waddr, cs_wdata, step,
    input  mir, mpc, running, halted
  );
  modport slave (
    input  start, alu_n, alu_z, mbr_opcode, cs_we, cs_waddr, cs_wdata, step,
    output mir, mpc, running, halted
  );
`else
  modport master (
    output start, alu_n, alu_z, mbr_opcode, cs_we, cs_waddr, cs_wdata,
    input  mir, mpc, running, halted
  );
  modport slave (
    input  start, alu_n, alu_z, mbr_opcode, cs_we, cs_waddr, cs_wdata,
    output mir, mpc, running, halted
  );
`endif

endinterface

// File: rtl/micro_next_addr.sv
// micro_next_addr: combinational next-microaddress formation from next_addr,
// JAMZ/JAMN flag injection into the MSB, and JMPC opcode OR-dispatch.
module micro_next_addr
  import micro_seq_pkg::*;
(
  input  logic [ADDR_W-1:0] next_addr,
  input  logic [JAM_W-1:0]  jam,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic [OPC_W-1:0]  mbr_opcode,
  output logic [ADDR_W-1:0] addr_c
);

  // OR-only arithmetic: no carries, cannot overflow
  always_comb begin
    addr_c = next_addr;
    if (jam[JAM_Z]) addr_c[ADDR_W-1] = addr_c[ADDR_W-1] | alu_z;
    if (jam[JAM_N]) addr_c[ADDR_W-1] = addr_c[ADDR_W-1] | alu_n;
    if (jam[JAM_PC]) addr_c = addr_c | ADDR_W'(mbr_opcode);
  end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: control store plus microprogram counter driving the mir
// bus, with per-word hold cycles and JAM-based branching.
// Optional feature macro: MICRO_SEQ_STEP_EN (advance EXEC only when step=1).
module micro_sequencer
  import micro_seq_pkg::*;
(
  input  logic clock,
  input  logic reset,
  micro_sequencer_if.slave bus
);

  cw_t               cs [CS_DEPTH];
  seq_state_e        state, state_nxt;
  logic [ADDR_W-1:0] mpc_q, mpc_nxt;
  logic [MIR_W-1:0]  mir_q, mir_nxt;
  logic [HOLD_W-1:0] hold_q, hold_nxt;
  logic [ADDR_W-1:0] na_q, na_nxt;
  logic [JAM_W-1:0]  jam_q, jam_nxt;
  logic              running_q, halted_q;
  logic              advance;
  logic [ADDR_W-1:0] branch_c;
  logic [ADDR_W-1:0] ld_addr_c;
  cw_t               ld_word_c;

`ifdef MICRO_SEQ_STEP_EN
  assign advance = bus.step;
`else
  assign advance = 1'b1;
`endif

  // Branch target from the word currently executing (latched at load time)
  micro_next_addr u_next_addr (
    .next_addr  (na_q),
    .jam        (jam_q),
    .alu_n      (bus.alu_n),
    .alu_z      (bus.alu_z),
    .mbr_opcode (bus.mbr_opcode),
    .addr_c     (branch_c)
  );

  // Start always fetches word 0; EXEC fetches the branch target
  assign ld_addr_c = (state == ST_EXEC) ? branch_c : '0;
  assign ld_word_c = cs[ld_addr_c];

  // Control store write port; reads above see the pre-write contents
  always_ff @(posedge clock) begin
    if (bus.cs_we) cs[bus.cs_waddr] <= cw_t'(bus.cs_wdata);
  end

  // Next-state and next-register values
  always_comb begin
    state_nxt = state;
    mpc_nxt   = mpc_q;
    mir_nxt   = mir_q;
    hold_nxt  = hold_q;
    na_nxt    = na_q;
    jam_nxt   = jam_q;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          state_nxt = ST_EXEC;
          mpc_nxt   = '0;
          mir_nxt   = ld_word_c.mir;
          hold_nxt  = ld_word_c.hold;
          na_nxt    = ld_word_c.next_addr;
          jam_nxt   = ld_word_c.jam;
        end
      end
      ST_EXEC: begin
        if (advance) begin
          if (hold_q != '0) begin
            hold_nxt = hold_q - HOLD_W'(1);
          end else if (branch_c == HALT_ADDR) begin
            state_nxt = ST_HALT;
            mpc_nxt   = HALT_ADDR;
            mir_nxt   = '0;
          end else begin
            mpc_nxt  = branch_c;
            mir_nxt  = ld_word_c.mir;
            hold_nxt = ld_word_c.hold;
            na_nxt   = ld_word_c.next_addr;
            jam_nxt  = ld_word_c.jam;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      mpc_q     <= '0;
      mir_q     <= '0;
      hold_q    <= '0;
      na_q      <= '0;
      jam_q     <= '0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      mpc_q     <= mpc_nxt;
      mir_q     <= mir_nxt;
      hold_q    <= hold_nxt;
      na_q      <= na_nxt;
      jam_q     <= jam_nxt;
      running_q <= (state_nxt == ST_EXEC);
      halted_q  <= (state_nxt == ST_HALT);
    end
  end

  assign bus.mir     = mir_q;
  assign bus.mpc     = mpc_q;
  assign bus.running = running_q;
  assign bus.halted  = halted_q;

endmodule
